// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   master_id_t : identifies which requester owns a transaction (M0 = core LSU,
//                 M1 = secondary DMA/debug master).
//   arb_state_t : arbiter state, free arbitration or locked onto one owner.
//   mem_req_t   : request attributes carried alongside req (we/be/addr/wdata).
//                 The struct is sized by ARB_AW/ARB_DW, which are also the
//                 defaults of the arbiter's AW/DW parameters.
package data_mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_DW/8-1:0]   be;
        logic [ARB_AW-1:0]     addr;
        logic [ARB_DW-1:0]     wdata;
    } mem_req_t;

    // After a handshake the winner drops to lowest priority.
    function automatic master_id_t other_master(input master_id_t id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_id_fifo.sv
// Outstanding-ID FIFO: records which master owns each granted-but-unanswered
// transaction so responses can be routed back in order.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push     : write push_id at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   head     : ID at the head, valid when !empty
//   count    : number of stored IDs, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module id_fifo
    import data_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  master_id_t                   push_id,
    input  logic                         pop,
    output master_id_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    // A depth-1 FIFO still needs a 1-bit pointer to index storage.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    master_id_t        id_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg,  count_next;
    logic              push_ok, pop_ok;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = id_mem[rd_ptr_reg];
    assign count   = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop_ok) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        // Simultaneous push and pop leaves the count unchanged.
        if (push_ok && !pop_ok) begin
            count_next = count_reg + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            id_mem[wr_ptr_reg] <= push_id;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of a single data-memory slave port using the
// req/gnt/rvalid protocol. Round-robin between m0 (core LSU) and m1 (DMA /
// debug), with the request locked onto its owner until granted, and in-order
// response routing through an outstanding-ID FIFO.
//   clk, rst              : clock, asynchronous active-high reset
//   mN_req_i .. mN_wdata_i: request channel from master N (N = 0, 1)
//   mN_gnt_o              : combinational grant to master N
//   mN_rvalid_o/rdata/err : response routed to master N
//   mem_*                 : request/response channel to the data memory
//   outstanding_o         : granted-but-unanswered transaction count
//   protocol_err_o        : sticky flag, set by an rvalid with nothing pending
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int AW              = ARB_AW,
    parameter int DW              = ARB_DW
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   m0_req_i,
    output logic                                   m0_gnt_o,
    input  logic                                   m0_we_i,
    input  logic [DW/8-1:0]                        m0_be_i,
    input  logic [AW-1:0]                          m0_addr_i,
    input  logic [DW-1:0]                          m0_wdata_i,
    output logic                                   m0_rvalid_o,
    output logic [DW-1:0]                          m0_rdata_o,
    output logic                                   m0_err_o,

    input  logic                                   m1_req_i,
    output logic                                   m1_gnt_o,
    input  logic                                   m1_we_i,
    input  logic [DW/8-1:0]                        m1_be_i,
    input  logic [AW-1:0]                          m1_addr_i,
    input  logic [DW-1:0]                          m1_wdata_i,
    output logic                                   m1_rvalid_o,
    output logic [DW-1:0]                          m1_rdata_o,
    output logic                                   m1_err_o,

    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic                                   mem_we_o,
    output logic [DW/8-1:0]                        mem_be_o,
    output logic [AW-1:0]                          mem_addr_o,
    output logic [DW-1:0]                          mem_wdata_o,
    input  logic                                   mem_rvalid_i,
    input  logic [DW-1:0]                          mem_rdata_i,
    input  logic                                   mem_err_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   protocol_err_o
);

    arb_state_t  state_reg, state_next;
    master_id_t  owner_reg, owner_next;
    master_id_t  rr_reg, rr_next;
    logic        protocol_err_reg, protocol_err_next;

    master_id_t  sel;
    logic        sel_req;
    mem_req_t    m0_req_s, m1_req_s, sel_req_s;
    logic        handshake;
    logic        rsp_valid;
    logic        fifo_pop;
    logic        fifo_full, fifo_empty;
    master_id_t  fifo_head;

    assign m0_req_s = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign m1_req_s = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

    // Owner selection. A locked owner cannot be displaced because a master
    // may not retract or change its request before it is granted.
    always_comb begin
        sel = M0;
        if (state_reg == LOCKED) begin
            sel = owner_reg;
        end else if (m0_req_i && m1_req_i) begin
            sel = rr_reg;
        end else if (m1_req_i) begin
            sel = M1;
        end
    end

    assign sel_req   = (sel == M1) ? m1_req_i : m0_req_i;
    assign sel_req_s = (sel == M1) ? m1_req_s : m0_req_s;

    // Full is registered state, so a same-cycle rvalid frees a slot only
    // for the following cycle. rst gates outputs so they drop immediately.
    assign mem_req_o   = sel_req && !fifo_full && !rst;
    assign mem_we_o    = rst ? 1'b0 : sel_req_s.we;
    assign mem_be_o    = rst ? '0   : sel_req_s.be;
    assign mem_addr_o  = rst ? '0   : sel_req_s.addr;
    assign mem_wdata_o = rst ? '0   : sel_req_s.wdata;

    assign handshake = mem_req_o && mem_gnt_i;
    assign m0_gnt_o  = handshake && (sel == M0);
    assign m1_gnt_o  = handshake && (sel == M1);

    // Responses follow grant order; an rvalid with nothing pending is dropped.
    assign rsp_valid   = mem_rvalid_i && !rst;
    assign fifo_pop    = rsp_valid && !fifo_empty;
    assign m0_rvalid_o = fifo_pop && (fifo_head == M0);
    assign m1_rvalid_o = fifo_pop && (fifo_head == M1);
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    assign m0_err_o    = m0_rvalid_o && mem_err_i;
    assign m1_err_o    = m1_rvalid_o && mem_err_i;

    // LOCKED is only entered while not full (mem_req_o implies !full), and
    // the count cannot rise while locked, so lock and full never coincide.
    always_comb begin
        state_next        = state_reg;
        owner_next        = owner_reg;
        rr_next           = rr_reg;
        protocol_err_next = protocol_err_reg || (rsp_valid && fifo_empty);
        if (handshake) begin
            state_next = ARB;
            rr_next    = other_master(sel);
        end else if (mem_req_o) begin
            state_next = LOCKED;
            owner_next = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ARB;
            owner_reg        <= M0;
            rr_reg           <= M0;
            protocol_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            owner_reg        <= owner_next;
            rr_reg           <= rr_next;
            protocol_err_reg <= protocol_err_next;
        end
    end

    assign protocol_err_o = protocol_err_reg;

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (handshake),
        .push_id (sel),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (outstanding_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter (MAX_OUTSTANDING = 2).
// Inputs are driven just after the falling edge and combinational outputs
// are sampled 1 ns later, well away from the rising edge.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]  outstanding_o;
    logic        protocol_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MAX_OUTSTANDING(2), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    task automatic clear_inputs();
        m0_req_i = 0; m0_we_i = 0; m0_be_i = 4'hF; m0_addr_i = 32'h200; m0_wdata_i = 32'h0;
        m1_req_i = 0; m1_we_i = 0; m1_be_i = 4'hF; m1_addr_i = 32'h300; m1_wdata_i = 32'h0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'h0; mem_err_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m0_req_i = 1; mem_gnt_i = 1;
        @(negedge clk); #1;
        n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
        n_tests++; if (m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_m0_gnt: got %b want 0", m0_gnt_o); end
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        n_tests++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", protocol_err_o); end
        n_tests++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_single_read();
        do_reset();
        clear_inputs();
        m0_req_i = 1; m0_addr_i = 32'h100; mem_gnt_i = 1;
        #1;
        n_tests++; if (m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", m0_gnt_o); end
        n_tests++; if (mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rd_addr: got %h want 00000100", mem_addr_o); end
        n_tests++; if (m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rd_m1_gnt: got %b want 0", m1_gnt_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (outstanding_o !== 2'd1) begin n_fail++; $display("FAIL rd_out1: got %0d want 1", outstanding_o); end
        n_tests++; if (m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rd_gnt_once: got %b want 0", m0_gnt_o); end
        @(negedge clk);
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b want 1", m0_rvalid_o); end
        n_tests++; if (m0_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", m0_rdata_o); end
        n_tests++; if (m1_rvalid_o !== 1'b0 || m1_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rd_m1_quiet: got rvalid %b rdata %h want 0/0", m1_rvalid_o, m1_rdata_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL rd_out0: got %0d want 0", outstanding_o); end
        $display("[TB] m0 read 0x100 -> 0xDEADBEEF");
    endtask

    task automatic test_alternate();
        logic       exp_m1;
        logic       prev_m1;
        logic [31:0] got_rdata;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_inputs();
            m0_req_i = 1; m1_req_i = 1; m1_we_i = 1; m1_wdata_i = 32'hC0DE0000 + i;
            mem_gnt_i = 1; mem_rvalid_i = (i > 0); mem_rdata_i = 32'hA0 + i;
            #1;
            exp_m1 = (i % 2 == 1);
            n_tests++; if ({m1_gnt_o, m0_gnt_o} !== (exp_m1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_gnt[%0d]: got m1/m0 %b%b want %b", i, m1_gnt_o, m0_gnt_o, exp_m1 ? 2'b10 : 2'b01); end
            n_tests++; if (mem_addr_o !== (exp_m1 ? 32'h300 : 32'h200) || mem_we_o !== exp_m1) begin n_fail++; $display("FAIL alt_mux[%0d]: got addr %h we %b want %h %b", i, mem_addr_o, mem_we_o, exp_m1 ? 32'h300 : 32'h200, exp_m1); end
            if (i > 0) begin
                prev_m1 = ((i - 1) % 2 == 1);
                got_rdata = prev_m1 ? m1_rdata_o : m0_rdata_o;
                n_tests++; if ({m1_rvalid_o, m0_rvalid_o} !== (prev_m1 ? 2'b10 : 2'b01) || got_rdata !== 32'hA0 + i) begin n_fail++; $display("FAIL alt_rsp[%0d]: got rvalid m1/m0 %b%b rdata %h want %b %h", i, m1_rvalid_o, m0_rvalid_o, got_rdata, prev_m1 ? 2'b10 : 2'b01, 32'hA0 + i); end
            end
            $display("[TB] alternate cycle %0d grant to m%0d", i, exp_m1 ? 1 : 0);
        end
        @(negedge clk);
        clear_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'hB5;
        #1;
        n_tests++; if (m1_rvalid_o !== 1'b1 || m1_rdata_o !== 32'hB5) begin n_fail++; $display("FAIL alt_last_rsp: got %b %h want 1 000000b5", m1_rvalid_o, m1_rdata_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL alt_drain: got %0d want 0", outstanding_o); end
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
            m1_req_i = 1; m0_req_i = (c == 2);
            #1;
            n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin n_fail++; $display("FAIL lock_hold[%0d]: got req %b addr %h want 1 00000300", c, mem_req_o, mem_addr_o); end
            n_tests++; if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL lock_nogrant[%0d]: got %b%b want 00", c, m1_gnt_o, m0_gnt_o); end
        end
        @(negedge clk);
        clear_inputs();
        m1_req_i = 1; m0_req_i = 1; mem_gnt_i = 1;
        #1;
        n_tests++; if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL lock_m1_gnt: got m1/m0 %b%b want 10", m1_gnt_o, m0_gnt_o); end
        $display("[TB] locked m1 granted");
        @(negedge clk);
        clear_inputs();
        m0_req_i = 1; mem_gnt_i = 1;
        #1;
        n_tests++; if (m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL lock_m0_next: got %b want 1", m0_gnt_o); end
        @(negedge clk);
        clear_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'h11;
        #1;
        n_tests++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL lock_rsp1: got m1/m0 %b%b want 10", m1_rvalid_o, m0_rvalid_o); end
        @(negedge clk);
        mem_rdata_i = 32'h22;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h22) begin n_fail++; $display("FAIL lock_rsp2: got %b %h want 1 00000022", m0_rvalid_o, m0_rdata_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            clear_inputs();
            m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h10 + 4 * c; m0_wdata_i = 32'h1000 + c; mem_gnt_i = 1;
            #1;
            n_tests++; if (m0_gnt_o !== 1'b1 || mem_wdata_o !== 32'h1000 + c) begin n_fail++; $display("FAIL full_wr[%0d]: got gnt %b wdata %h want 1 %h", c, m0_gnt_o, mem_wdata_o, 32'h1000 + c); end
            $display("[TB] m0 write %0d granted", c);
        end
        @(negedge clk);
        m0_addr_i = 32'h18; m0_wdata_i = 32'h1002;
        #1;
        n_tests++; if (outstanding_o !== 2'd2 || mem_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL full_block: got out %0d req %b gnt %b want 2 0 0", outstanding_o, mem_req_o, m0_gnt_o); end
        @(negedge clk);
        mem_rvalid_i = 1;
        #1;
        n_tests++; if (mem_req_o !== 1'b0 || m0_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL full_rv_same: got req %b rvalid %b want 0 1", mem_req_o, m0_rvalid_o); end
        @(negedge clk);
        mem_rvalid_i = 0;
        #1;
        n_tests++; if (outstanding_o !== 2'd1 || m0_gnt_o !== 1'b1 || mem_addr_o !== 32'h18) begin n_fail++; $display("FAIL full_resume: got out %0d gnt %b addr %h want 1 1 00000018", outstanding_o, m0_gnt_o, mem_addr_o); end
        @(negedge clk);
        clear_inputs();
        mem_rvalid_i = 1;
        @(negedge clk);
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b1 || outstanding_o !== 2'd1) begin n_fail++; $display("FAIL full_drain: got rvalid %b out %0d want 1 1", m0_rvalid_o, outstanding_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        clear_inputs();
        m0_req_i = 1; mem_gnt_i = 1;
        @(negedge clk);
        clear_inputs();
        m1_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'h55 || m1_gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_same: got rvalid %b rdata %h gnt1 %b want 1 00000055 1", m0_rvalid_o, m0_rdata_o, m1_gnt_o); end
        n_tests++; if (m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_m1_quiet: got %b want 0", m1_rvalid_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (outstanding_o !== 2'd1) begin n_fail++; $display("FAIL b2b_count: got %0d want 1", outstanding_o); end
        mem_rvalid_i = 1; mem_err_i = 1;
        #1;
        n_tests++; if (m1_rvalid_o !== 1'b1 || m1_err_o !== 1'b1 || m0_err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_m1_rsp: got rvalid %b err %b err0 %b want 1 1 0", m1_rvalid_o, m1_err_o, m0_err_o); end
        $display("[TB] same-cycle grant m1 / response m0");
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_protocol_err();
        do_reset();
        @(negedge clk);
        clear_inputs();
        mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'h77;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0 || m0_err_o !== 1'b0 || m1_err_o !== 1'b0) begin n_fail++; $display("FAIL perr_drop: got rvalid %b%b err %b%b want 0000", m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", protocol_err_o); end
        n_tests++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL perr_count: got %0d want 0", outstanding_o); end
        @(negedge clk);
        m0_req_i = 1; mem_gnt_i = 1;
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (protocol_err_o !== 1'b1 || outstanding_o !== 2'd1) begin n_fail++; $display("FAIL perr_sticky: got perr %b out %0d want 1 1", protocol_err_o, outstanding_o); end
        // Reset mid-transaction with live inputs: outputs must drop at once.
        m0_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        rst = 1'b1;
        #1;
        n_tests++; if (m0_gnt_o !== 1'b0 || mem_req_o !== 1'b0 || m0_rvalid_o !== 1'b0 || mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_out: got gnt %b req %b rvalid %b addr %h want 0 0 0 0", m0_gnt_o, mem_req_o, m0_rvalid_o, mem_addr_o); end
        n_tests++; if (outstanding_o !== 2'd0 || protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got out %0d perr %b want 0 0", outstanding_o, protocol_err_o); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid_i = 1;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_rv: got %b want 0", m0_rvalid_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL rst_late_perr: got %b want 1", protocol_err_o); end
        $display("[TB] late rvalid after reset flagged");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_full();
        test_back_to_back();
        test_protocol_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares one data-memory slave port between two requesters using the same req/gnt/rvalid protocol as the core's data interface.
- m0 is the core LSU; m1 is a secondary master (DMA/debug).
- Round-robin arbitration with request locking; in-order response routing via an outstanding-ID FIFO.
- Sits between the core data port plus the secondary master and the data memory model/responder in the bench top.

Parameters:
- MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (1..8).
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- mN_req_i  input  1  request from master N (N = 0, 1; same for all mN ports below).
- mN_gnt_o  output  1  grant to master N.
- mN_we_i  input  1  write enable.
- mN_be_i  input  DW/8  byte enables.
- mN_addr_i  input  AW  address.
- mN_wdata_i  input  DW  write data.
- mN_rvalid_o  output  1  response valid.
- mN_rdata_o  output  DW  read data.
- mN_err_o  output  1  response error.
- mem_req_o  output  1  request to memory.
- mem_gnt_i  input  1  memory grant.
- mem_we_o  output  1  write enable to memory.
- mem_be_o  output  DW/8  byte enables to memory.
- mem_addr_o  output  AW  address to memory.
- mem_wdata_o  output  DW  write data to memory.
- mem_rvalid_i  input  1  memory response valid.
- mem_rdata_i  input  DW  memory read data.
- mem_err_i  input  1  memory response error.
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
- protocol_err_o  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied, count 0, rr pointer = m0 priority, lock cleared, protocol_err_o=0.
  - All gnt/rvalid/req outputs 0; data outputs 0.
- States: ARB (no lock) and LOCKED (owner held).
  - In ARB, selection is combinational among asserted reqs.
  - If both request, the rr-priority master wins.
  - If exactly one requests, it wins.
- Full condition: count == MAX_OUTSTANDING.
  - mem_req_o = selected master's req && !full.
  - Address/we/be/wdata muxed from the selected master.
- Grant:
  - mX_gnt_o = mem_gnt_i && mem_req_o && (sel==X); combinational, zero added latency.
  - The non-selected master's gnt is always 0.
- Lock: if mem_req_o=1 and mem_gnt_i=0, enter LOCKED on the selected owner.
  - Owner holds until its handshake, even if the other master requests.
  - Required because masters may not retract or alter req before gnt.
  - On handshake, return to ARB.
  - While full, arbitration is frozen and no lock is taken.
- Handshake (mem_req_o && mem_gnt_i):
  - Push the owner ID into the FIFO.
  - rr pointer moves to the other master (the winner becomes lowest priority).
- Response:
  - mem_rvalid_i routes to the FIFO head ID: that master gets rvalid/err, and rdata = mem_rdata_i.
  - The other master gets rvalid=0; its rdata is held at 0.
  - Pop the FIFO head. Combinational routing, zero latency.
- Same-cycle handshake and rvalid: pop and push together, count unchanged; head ordering preserved.
- A full FIFO with simultaneous rvalid does not unblock a grant in the same cycle; the grant resumes next cycle.
- rvalid with an empty FIFO:
  - Response dropped; no master sees rvalid.
  - protocol_err_o set, sticky until reset.
- Count stays within 0..MAX_OUTSTANDING; no wrap. FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction: in-flight IDs discarded; late rvalids after reset raise protocol_err_o.

Decomposition:
- Package data_mem_arb_pkg:
  - typedef master_id_t (1-bit enum M0, M1).
  - typedef arb_state_t (ARB, LOCKED).
  - Request struct {we, be, addr, wdata}.
- Sub-module: id_fifo, a parameterised sync FIFO (depth MAX_OUTSTANDING) with push, pop, head, count, full and empty.

Test Plan:
- Single m0 read at 0x100, mem gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF: m0_gnt_o pulses once; m0_rvalid_o=1 with rdata 0xDEADBEEF; m1_rvalid_o stays 0; outstanding goes 1 then 0.
- m0 and m1 both requesting continuously, mem_gnt_i=1, rvalid 1 cycle after each grant: grants alternate m0, m1, m0, m1; responses route to the matching master in order.
- m1 requests with mem_gnt_i held 0 for 3 cycles, m0 raises req in cycle 2: m1 stays locked; m1 granted when gnt arrives; m0 granted the next cycle.
- MAX_OUTSTANDING=2:
  - m0 issues 3 back-to-back writes with no rvalid; the 3rd is not presented and mem_req_o=0 while outstanding=2.
  - One rvalid arrives; the 3rd is granted the following cycle.
- Same-cycle new grant to m1 and rvalid for an earlier m0 request: m0_rvalid_o=1, m1_gnt_o=1, outstanding unchanged.
- rvalid with mem_err_i=1 on an empty FIFO: no master rvalid and protocol_err_o=1 until reset. rst pulse mid-transaction (1 outstanding): all outputs 0 immediately, outstanding_o=0.
